// File: rtl/pairing_host_pkg.sv
// rtl/pairing_host_pkg.sv - shared types and encodings for the pairing host sequencer
package pairing_host_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int RAM_ADDR_SIZE    = 8;
    localparam int CMD_INSTTYPE     = 4;
    localparam int I_INPUTMODE_SIZE = 2;
    localparam int NLANES           = 24;

    // Existing top.I_INPUTMODE encodings
    localparam logic [I_INPUTMODE_SIZE-1:0] INPUT_IDLE       = 2'd0;
    localparam logic [I_INPUTMODE_SIZE-1:0] INPUT_COORD_CORE = 2'd1;
    localparam logic [I_INPUTMODE_SIZE-1:0] INPUT_RUN        = 2'd2;
    localparam logic [I_INPUTMODE_SIZE-1:0] REF_RESULT       = 2'd3;

    localparam logic [I_INPUTMODE_SIZE-1:0] MODE_IDLE = INPUT_IDLE;
    localparam logic [I_INPUTMODE_SIZE-1:0] MODE_LOAD = INPUT_COORD_CORE;
    localparam logic [I_INPUTMODE_SIZE-1:0] MODE_RUN  = INPUT_RUN;
    localparam logic [I_INPUTMODE_SIZE-1:0] MODE_READ = REF_RESULT;

    localparam logic [RAM_ADDR_SIZE-1:0] RAM_P_BT_0 = 8'h20;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'd0,
        OP_RUN     = 2'd1,
        OP_READ    = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_COLLECT,
        ST_LD_WRITE,
        ST_RUN_ISSUE,
        ST_RUN_ARM,
        ST_RUN_WAIT,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_STREAM
    } state_e;

    // Lane index for result/wdata suffix abcd
    function automatic int lane_of(input int a, input int b, input int c, input int d);
        return 12 * a + 4 * b + 2 * c + d;
    endfunction

endpackage

// File: rtl/pairing_host_ctrl_if.sv
// rtl/pairing_host_ctrl_if.sv - host command, load and result stream bundle
interface pairing_host_ctrl_if #(
    parameter int W  = 32,
    parameter int AW = 8,
    parameter int IW = 4
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [IW-1:0] cmd_inst;

    logic          din_valid;
    logic          din_ready;
    logic [W-1:0]  din_data;

    logic          dout_valid;
    logic          dout_ready;
    logic [W-1:0]  dout_data;
    logic          dout_last;

    logic          done;
    logic          err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_inst, din_valid, din_data, dout_ready,
        input  cmd_ready, din_ready, dout_valid, dout_data, dout_last, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_inst, din_valid, din_data, dout_ready,
        output cmd_ready, din_ready, dout_valid, dout_data, dout_last, done, err
    );
endinterface

// File: rtl/lane_buffer.sv
// rtl/lane_buffer.sv - 24-lane word register file with indexed write and parallel load
module lane_buffer
    import pairing_host_pkg::*;
#(
    parameter int W = WORD_SIZE,
    parameter int N = NLANES
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [4:0]     wr_idx,
    input  logic [W-1:0]   wr_data,
    input  logic           ld_en,
    input  logic [N*W-1:0] ld_data,
    output logic [N*W-1:0] q
);
    logic [N*W-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (ld_en) begin
            mem <= ld_data;
        end else if (wr_en && (wr_idx < 5'(N))) begin
            mem[wr_idx*W +: W] <= wr_data;
        end
    end

    assign q = mem;
endmodule

// File: rtl/pairing_host_ctrl.sv
// rtl/pairing_host_ctrl.sv - sequences host LOAD/RUN/READ commands onto the pairing core port
module pairing_host_ctrl
    import pairing_host_pkg::*;
#(
    parameter int W      = WORD_SIZE,
    parameter int AW     = RAM_ADDR_SIZE,
    parameter int RD_LAT = 2,
    parameter int ARM_TO = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pairing_host_ctrl_if.slave          host,
    output logic [I_INPUTMODE_SIZE-1:0] o_inputmode,
    output logic [CMD_INSTTYPE-1:0]     o_insttype,
    output logic [AW-1:0]               o_waddr,
    output logic [AW-1:0]               o_raddr,
    output logic [NLANES*W-1:0]         o_wdata,
    input  logic [NLANES*W-1:0]         i_result,
    input  logic                        i_busy
);
    localparam int CW = 8;
    localparam logic [4:0] LAST_LANE = 5'(NLANES - 1);

    state_e        state;
    logic [4:0]    cnt;
    logic [CW-1:0] wait_cnt;
    logic [AW-1:0] addr_q;

    logic cmd_ready_r, din_ready_r, dout_valid_r, dout_last_r, done_r, err_r;

    logic                 ld_wr_en;
    logic                 res_ld_en;
    logic [NLANES*W-1:0]  res_q;

    assign ld_wr_en  = (state == ST_LD_COLLECT) && host.din_valid && din_ready_r;
    assign res_ld_en = (state == ST_RD_WAIT) && (wait_cnt == CW'(RD_LAT - 1));

    lane_buffer #(.W(W), .N(NLANES)) u_load_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ld_wr_en),
        .wr_idx  (cnt),
        .wr_data (host.din_data),
        .ld_en   (1'b0),
        .ld_data ('0),
        .q       (o_wdata)
    );

    lane_buffer #(.W(W), .N(NLANES)) u_result_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (1'b0),
        .wr_idx  (5'd0),
        .wr_data ('0),
        .ld_en   (res_ld_en),
        .ld_data (i_result),
        .q       (res_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            wait_cnt     <= '0;
            addr_q       <= '0;
            cmd_ready_r  <= 1'b0;
            din_ready_r  <= 1'b0;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            o_inputmode  <= MODE_IDLE;
            o_insttype   <= '0;
            o_waddr      <= '0;
            o_raddr      <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready_r <= 1'b1;
                    if (host.cmd_valid && cmd_ready_r) begin
                        addr_q <= host.cmd_addr;
                        case (host.cmd_op)
                            OP_LOAD: begin
                                state       <= ST_LD_COLLECT;
                                cmd_ready_r <= 1'b0;
                                din_ready_r <= 1'b1;
                                cnt         <= '0;
                            end
                            OP_RUN: begin
                                state       <= ST_RUN_ISSUE;
                                cmd_ready_r <= 1'b0;
                                o_inputmode <= MODE_RUN;
                                o_insttype  <= host.cmd_inst;
                            end
                            OP_READ: begin
                                state       <= ST_RD_ADDR;
                                cmd_ready_r <= 1'b0;
                                o_inputmode <= MODE_READ;
                                o_raddr     <= host.cmd_addr;
                                wait_cnt    <= '0;
                            end
                            default: err_r <= 1'b1;
                        endcase
                    end
                end

                ST_LD_COLLECT: begin
                    if (ld_wr_en) begin
                        if (cnt == LAST_LANE) begin
                            state       <= ST_LD_WRITE;
                            din_ready_r <= 1'b0;
                            cnt         <= '0;
                            o_inputmode <= MODE_LOAD;
                            o_waddr     <= addr_q;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end

                ST_LD_WRITE: begin
                    o_inputmode <= MODE_IDLE;
                    done_r      <= 1'b1;
                    cmd_ready_r <= 1'b1;
                    state       <= ST_IDLE;
                end

                ST_RUN_ISSUE: begin
                    o_inputmode <= MODE_IDLE;
                    wait_cnt    <= '0;
                    state       <= ST_RUN_ARM;
                end

                ST_RUN_ARM: begin
                    if (i_busy) begin
                        state <= ST_RUN_WAIT;
                    end else if (wait_cnt == CW'(ARM_TO - 1)) begin
                        err_r       <= 1'b1;
                        cmd_ready_r <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_RUN_WAIT: begin
                    if (!i_busy) begin
                        done_r      <= 1'b1;
                        cmd_ready_r <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                ST_RD_ADDR: begin
                    state <= ST_RD_WAIT;
                end

                // Result lanes are captured on the edge that leaves this state
                ST_RD_WAIT: begin
                    if (res_ld_en) begin
                        o_inputmode <= MODE_IDLE;
                        cnt         <= '0;
                        state       <= ST_RD_STREAM;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // First cycle here only raises valid, once the capture has settled
                ST_RD_STREAM: begin
                    if (!dout_valid_r) begin
                        dout_valid_r <= 1'b1;
                        dout_last_r  <= (cnt == LAST_LANE);
                    end else if (host.dout_ready) begin
                        if (cnt == LAST_LANE) begin
                            dout_valid_r <= 1'b0;
                            dout_last_r  <= 1'b0;
                            cnt          <= '0;
                            done_r       <= 1'b1;
                            cmd_ready_r  <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            cnt         <= cnt + 5'd1;
                            dout_last_r <= ((cnt + 5'd1) == LAST_LANE);
                        end
                    end
                end

                default: begin
                    o_inputmode <= MODE_IDLE;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign host.cmd_ready  = cmd_ready_r;
    assign host.din_ready  = din_ready_r;
    assign host.dout_valid = dout_valid_r;
    assign host.dout_last  = dout_last_r;
    assign host.dout_data  = res_q[cnt*W +: W];
    assign host.done       = done_r;
    assign host.err        = err_r;
endmodule

// File: tb/tb_pairing_host_ctrl.sv
// tb/tb_pairing_host_ctrl.sv - directed self-checking bench for pairing_host_ctrl
module tb_pairing_host_ctrl;
    import pairing_host_pkg::*;

    localparam int W      = WORD_SIZE;
    localparam int AW     = RAM_ADDR_SIZE;
    localparam int IW     = CMD_INSTTYPE;
    localparam int MW     = I_INPUTMODE_SIZE;
    localparam int RD_LAT = 2;
    localparam int ARM_TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pairing_host_ctrl_if #(.W(W), .AW(AW), .IW(IW)) hif ();

    logic [MW-1:0]        o_inputmode;
    logic [IW-1:0]        o_insttype;
    logic [AW-1:0]        o_waddr;
    logic [AW-1:0]        o_raddr;
    logic [NLANES*W-1:0]  o_wdata;
    logic [NLANES*W-1:0]  i_result;
    logic                 i_busy;

    pairing_host_ctrl #(.W(W), .AW(AW), .RD_LAT(RD_LAT), .ARM_TO(ARM_TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (hif),
        .o_inputmode (o_inputmode),
        .o_insttype  (o_insttype),
        .o_waddr     (o_waddr),
        .o_raddr     (o_raddr),
        .o_wdata     (o_wdata),
        .i_result    (i_result),
        .i_busy      (i_busy)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   k;
    int   c0;
    logic rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [W-1:0] lane(input int idx);
        return o_wdata[idx*W +: W];
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [IW-1:0] inst);
        chk("cmd_ready_pre", 64'(hif.cmd_ready), 64'd1);
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_addr  = a;
        hif.cmd_inst  = inst;
        step();
        hif.cmd_valid = 1'b0;
    endtask

    task automatic do_load(input string tg, input logic [AW-1:0] a, input logic [W-1:0] base, input int gap);
        int t0;
        int gaps;
        gaps = 0;
        send_cmd(OP_LOAD, a, '0);
        t0 = cyc;
        chk({tg, "_din_ready"}, 64'(hif.din_ready), 64'd1);
        chk({tg, "_cmd_ready"}, 64'(hif.cmd_ready), 64'd0);
        for (int b = 0; b < NLANES; b++) begin
            if (gap > 0 && (b % gap) == 1) begin
                hif.din_valid = 1'b0;
                hif.din_data  = 32'hDEAD_BEEF;
                step();
                gaps++;
            end
            hif.din_valid = 1'b1;
            hif.din_data  = base + W'(b);
            step();
        end
        hif.din_valid = 1'b0;
        chk({tg, "_mode_load"}, 64'(o_inputmode), 64'(MODE_LOAD));
        chk({tg, "_waddr"}, 64'(o_waddr), 64'(a));
        chk({tg, "_lane0000"}, 64'(lane(lane_of(0, 0, 0, 0))), 64'(base));
        chk({tg, "_lane0211"}, 64'(lane(11)), 64'(base + 32'd11));
        chk({tg, "_lane1211"}, 64'(lane(lane_of(1, 2, 1, 1))), 64'(base + 32'd23));
        chk({tg, "_no_early_done"}, 64'(hif.done), 64'd0);
        step();
        chk({tg, "_done"}, 64'(hif.done), 64'd1);
        chk({tg, "_done_cycle"}, 64'(cyc - t0), 64'(25 + gaps));
        chk({tg, "_mode_idle"}, 64'(o_inputmode), 64'(MODE_IDLE));
        chk({tg, "_cmd_ready_back"}, 64'(hif.cmd_ready), 64'd1);
        step();
        chk({tg, "_done_pulse"}, 64'(hif.done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        hif.cmd_valid  = 1'b0;
        hif.cmd_op     = '0;
        hif.cmd_addr   = '0;
        hif.cmd_inst   = '0;
        hif.din_valid  = 1'b0;
        hif.din_data   = '0;
        hif.dout_ready = 1'b0;
        i_busy         = 1'b0;
        for (int i = 0; i < NLANES; i++) i_result[i*W +: W] = 32'h100 + 32'(i);

        repeat (3) step();
        chk("rst_cmd_ready", 64'(hif.cmd_ready), 64'd0);
        chk("rst_din_ready", 64'(hif.din_ready), 64'd0);
        chk("rst_dout_valid", 64'(hif.dout_valid), 64'd0);
        chk("rst_done_err", {62'd0, hif.done, hif.err}, 64'd0);
        chk("rst_mode", 64'(o_inputmode), 64'(MODE_IDLE));
        chk("rst_wdata_zero", 64'(|o_wdata), 64'd0);
        rst_n = 1'b1;
        step();
        chk("cmd_ready_after_rst", 64'(hif.cmd_ready), 64'd1);

        do_load("ld1", RAM_P_BT_0, 32'h01, 0);

        // READ with toggling backpressure
        send_cmd(OP_READ, 8'h44, '0);
        chk("rd_mode", 64'(o_inputmode), 64'(MODE_READ));
        chk("rd_raddr", 64'(o_raddr), 64'h44);
        step();
        step();
        chk("rd_mode_held", 64'(o_inputmode), 64'(MODE_READ));
        chk("rd_no_early_valid", 64'(hif.dout_valid), 64'd0);
        step();
        chk("rd_mode_off", 64'(o_inputmode), 64'(MODE_IDLE));
        chk("rd_no_valid_lat1", 64'(hif.dout_valid), 64'd0);
        for (int i = 0; i < NLANES; i++) i_result[i*W +: W] = 32'hBAD0_0000 + 32'(i);
        step();
        k   = 0;
        rdy = 1'b0;
        for (int t = 0; t < 200 && k < NLANES; t++) begin
            chk("rd_valid", 64'(hif.dout_valid), 64'd1);
            chk("rd_data", 64'(hif.dout_data), 64'(32'h100 + 32'(k)));
            chk("rd_last", 64'(hif.dout_last), 64'(k == NLANES - 1));
            chk("rd_cmd_ready_low", 64'(hif.cmd_ready), 64'd0);
            rdy = (t % 2) == 1;
            hif.dout_ready = rdy;
            step();
            if (rdy) k++;
        end
        hif.dout_ready = 1'b0;
        chk("rd_beats", 64'(k), 64'(NLANES));
        chk("rd_done", 64'(hif.done), 64'd1);
        chk("rd_valid_drop", 64'(hif.dout_valid), 64'd0);
        step();
        chk("rd_done_pulse", 64'(hif.done), 64'd0);

        // RUN with busy high for 10 cycles
        send_cmd(OP_RUN, '0, 4'h5);
        chk("run_mode", 64'(o_inputmode), 64'(MODE_RUN));
        chk("run_inst", 64'(o_insttype), 64'h5);
        chk("run_cmd_ready", 64'(hif.cmd_ready), 64'd0);
        step();
        chk("run_mode_off", 64'(o_inputmode), 64'(MODE_IDLE));
        i_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("run_busy_cmd_ready", 64'(hif.cmd_ready), 64'd0);
            chk("run_busy_no_done", {62'd0, hif.done, hif.err}, 64'd0);
        end
        i_busy = 1'b0;
        step();
        chk("run_done", 64'(hif.done), 64'd1);
        chk("run_cmd_ready_back", 64'(hif.cmd_ready), 64'd1);
        step();
        chk("run_done_pulse", 64'(hif.done), 64'd0);

        // RUN with busy never rising
        send_cmd(OP_RUN, '0, 4'h3);
        c0 = cyc;
        for (int i = 0; i < ARM_TO; i++) begin
            step();
            chk("arm_no_err_yet", 64'(hif.err), 64'd0);
        end
        step();
        chk("arm_err", 64'(hif.err), 64'd1);
        chk("arm_err_cycle", 64'(cyc - c0), 64'(ARM_TO + 1));
        chk("arm_no_done", 64'(hif.done), 64'd0);
        chk("arm_idle", 64'(hif.cmd_ready), 64'd1);
        step();
        chk("arm_err_pulse", 64'(hif.err), 64'd0);

        // Illegal op
        send_cmd(2'd3, 8'h11, '0);
        chk("ill_err", 64'(hif.err), 64'd1);
        chk("ill_cmd_ready", 64'(hif.cmd_ready), 64'd1);
        chk("ill_mode", 64'(o_inputmode), 64'(MODE_IDLE));
        step();
        chk("ill_err_pulse", 64'(hif.err), 64'd0);
        chk("ill_din_ready", 64'(hif.din_ready), 64'd0);

        // Reset in the middle of a load
        send_cmd(OP_LOAD, 8'h55, '0);
        for (int b = 0; b < 10; b++) begin
            hif.din_valid = 1'b1;
            hif.din_data  = 32'h70 + 32'(b);
            step();
        end
        hif.din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 64'(hif.cmd_ready), 64'd0);
        chk("mid_rst_din_ready", 64'(hif.din_ready), 64'd0);
        chk("mid_rst_wdata", 64'(|o_wdata), 64'd0);
        chk("mid_rst_mode", 64'(o_inputmode), 64'(MODE_IDLE));
        chk("mid_rst_waddr", 64'(o_waddr), 64'd0);
        step();
        chk("mid_rst_no_done", 64'(hif.done), 64'd0);
        rst_n = 1'b1;
        step();
        chk("mid_rst_ready_back", 64'(hif.cmd_ready), 64'd1);

        do_load("ld2", RAM_P_BT_0 + 8'd3, 32'hA0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pairing_host_ctrl.md
# pairing_host_ctrl

Host-side sequencer for the BLS24 pairing `top`. Sits between a word-serial host bus and `top`'s wide load/run/readback port. Turns three host commands (LOAD, RUN, READ) into correctly timed `I_INPUTMODE`/`I_INSTTYPE`/`I_WADDR`/`I_RADDR`/`I_WDATA*` sequences. Packs 24 host words into one Fp24 element, tracks `is_busy`, and serializes the 24-lane result back to the host.

## Interface
- `W`, default `WORD_SIZE`: word width.
- `AW`, default `RAM_ADDR_SIZE`: RAM address width.
- `RD_LAT`, default 2: cycles from `I_RADDR`/REF_RESULT presentation to valid `result*`.
- `ARM_TO`, default 4: cycles allowed for `is_busy` to rise after RUN issue.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 2: 0 LOAD, 1 RUN, 2 READ, 3 illegal.
- `cmd_addr` in AW: RAM address for LOAD/READ.
- `cmd_inst` in `CMD_INSTTYPE`: instruction type for RUN.
- `din_valid` in 1, `din_ready` out 1, `din_data` in W: load word stream.
- `dout_valid` out 1, `dout_ready` in 1, `dout_data` out W, `dout_last` out 1: result stream.
- `done` out 1: one-cycle pulse when any command completes.
- `err` out 1: one-cycle pulse on illegal op or arm timeout.
- `o_inputmode` out `I_INPUTMODE_SIZE`: drives `top.I_INPUTMODE`.
- `o_insttype` out `CMD_INSTTYPE`: drives `top.I_INSTTYPE`.
- `o_waddr`, `o_raddr` out AW: drive `top.I_WADDR` / `top.I_RADDR`.
- `o_wdata` out 24*W: lanes 0..23 drive `I_WDATA0000..I_WDATA1211`.
- `i_result` in 24*W: lanes 0..23 come from `result0000..result1211`.
- `i_busy` in 1: from `top.is_busy`.

## Operation
- Lane map: lane = 12a+4b+2c+d for suffix abcd. Lane 0 is 0000, lane 23 is 1211. Host word k corresponds to lane k.
- FSM states: IDLE, LD_COLLECT, LD_WRITE, RUN_ISSUE, RUN_ARM, RUN_WAIT, RD_ADDR, RD_WAIT, RD_STREAM.
- IDLE: `cmd_ready`=1. Accepting a command latches addr and inst.
  - LOAD goes to LD_COLLECT.
  - RUN goes to RUN_ISSUE.
  - READ goes to RD_ADDR.
  - op 3: `err` pulse, stay in IDLE.
- LD_COLLECT: `din_ready`=1. Each beat writes `din_data` into lane `cnt` and increments `cnt` (5 bits). The beat with `cnt`=23 moves to LD_WRITE.
- LD_WRITE, one cycle: `o_inputmode`=MODE_LOAD (`INPUT_COORD_CORE`), `o_waddr`=latched addr. Then `done`, return to IDLE.
- RUN_ISSUE, one cycle: `o_inputmode`=MODE_RUN, `o_insttype`=latched inst. Next state RUN_ARM.
- RUN_ARM: if `i_busy`=1, go to RUN_WAIT. After ARM_TO cycles without busy, `err` pulse and return to IDLE.
- RUN_WAIT: when `i_busy`=0, `done` pulse and return to IDLE.
- RD_ADDR / RD_WAIT: `o_inputmode`=MODE_READ (`REF_RESULT`) and `o_raddr` held for RD_LAT+1 cycles. On the last cycle, all 24 lanes of `i_result` are captured into an internal buffer. Next state RD_STREAM.
- RD_STREAM: `dout_data`=buffer[`cnt`]. `cnt` advances on `dout_valid && dout_ready`. `dout_last`=1 when `cnt`=23. The beat carrying last pulses `done` and returns to IDLE.
- `o_inputmode` is MODE_IDLE in every cycle not listed above. `o_wdata` holds the last loaded element.

## Timing
- Reset values: all outputs 0, `o_inputmode`=MODE_IDLE, FSM=IDLE, `cnt`=0. `cmd_ready` rises in the first cycle after `rst_n` deasserts.
- LOAD with no stalls takes 1 cmd cycle + 24 beats + 1 write cycle. `done` appears 25 cycles after the cmd handshake.
- READ: first `dout_valid` appears RD_LAT+2 cycles after the cmd handshake. 24 beats follow, with no bubbles if `dout_ready`=1.
- Backpressure: `dout_data` and `dout_last` stay stable while `dout_valid && !dout_ready`. `din_valid` gaps stall `cnt` with no loss.
- `cmd_ready`=0 in all non-IDLE states. Commands are never queued.
- `i_busy` already high in RUN_ARM on the first cycle: accepted, go to RUN_WAIT.
- `rst_n` low in any state: immediate return to IDLE. Partial load and read buffers are discarded, no `done`.

## Structure
- Package `pairing_host_pkg`:
  - op codes;
  - MODE_IDLE/LOAD/RUN/READ, mapped onto the existing `I_INPUTMODE` encodings;
  - the state enum;
  - NLANES=24.
- One sub-module, `lane_buffer`: a 24×W register file with a 5-bit index write port and a parallel load/read port. It is instantiated twice: load assembly and result capture.

## Test plan
- LOAD at addr `RAM_P_BT_0` with words 0x01..0x18: after 24 beats, LD_WRITE shows MODE_LOAD, `o_waddr`=`RAM_P_BT_0`, lane 0000=0x01, lane 1211=0x18; `done` at cycle +25.
- READ with `i_result` lane k = 0x100+k, `dout_ready` toggling every cycle: 24 beats 0x100..0x117, `dout_last` only on 0x117, data stable across stalls.
- RUN with `i_busy` high 10 cycles starting 2 cycles after issue: `done` exactly 1 cycle after busy falls. `cmd_ready` stays 0 throughout.
- RUN with `i_busy` never asserted: `err` pulse after ARM_TO=4 cycles, back in IDLE, no `done`.
- `cmd_op`=3: `err` pulse, no mode change, `cmd_ready` stays 1.
- `rst_n` pulsed after 10 load beats: all outputs at reset values. A fresh 24-beat LOAD then completes correctly.
